// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle control FSM for the RV32I-subset core.
// Steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB. Each cycle it drives
// that cycle's enables, mux selects and ALU operation. It also runs the req/ready
// handshakes with instruction and data memory.
// Optional feature: define MULTICYCLE_CTRL_PERF_EN to build the cycle and
// retired-instruction counters. Otherwise both counter outputs are tied to zero.
module multicycle_controller #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            alu_zero,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            pc_write,
    output logic            pc_src,
    output logic            ir_write,
    output logic            reg_write,
    output logic            alu_src_b,
    output logic            result_src,
    output logic [2:0]      alu_op,
    output logic            illegal,
    output logic [3:0]      state_out,
    output logic [XLEN-1:0] cycle_count,
    output logic [XLEN-1:0] instret_count
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StMemAddr = 4'd4,
        StMemRd   = 4'd5,
        StMemWr   = 4'd6,
        StWbAlu   = 4'd7,
        StWbMem   = 4'd8,
        StBranch  = 4'd9,
        StIllegal = 4'd15
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluAnd = 3'd2;
    localparam logic [2:0] AluOr  = 3'd3;
    localparam logic [2:0] AluXor = 3'd4;
    localparam logic [2:0] AluSll = 3'd5;
    localparam logic [2:0] AluSrl = 3'd6;
    localparam logic [2:0] AluSlt = 3'd7;

    state_e     state_q;
    state_e     state_d;
    logic [3:0] alu_dec;

    // Returns {legal, alu_op} for an R/I funct3. funct3 011 is not supported and
    // reports ADD with legal cleared.
    function automatic logic [3:0] decode_alu(input logic [2:0] f3, input logic sub);
        logic [3:0] r;
        r = {1'b1, AluAdd};
        case (f3)
            3'b000:  r = {1'b1, (sub ? AluSub : AluAdd)};
            3'b001:  r = {1'b1, AluSll};
            3'b010:  r = {1'b1, AluSlt};
            3'b011:  r = {1'b0, AluAdd};
            3'b100:  r = {1'b1, AluXor};
            3'b101:  r = {1'b1, AluSrl};
            3'b110:  r = {1'b1, AluOr};
            default: r = {1'b1, AluAnd};
        endcase
        return r;
    endfunction

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle datapath control decode.
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_b  = 1'b0;
        result_src = 1'b0;
        alu_op     = AluAdd;
        illegal    = 1'b0;
        alu_dec    = 4'b0;

        case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                case (opcode)
                    OpR:              state_d = StExecR;
                    OpI:              state_d = StExecI;
                    OpLoad, OpStore:  state_d = StMemAddr;
                    OpBranch:         state_d = StBranch;
                    default:          state_d = StIllegal;
                endcase
            end
            StExecR: begin
                alu_dec = decode_alu(funct3, funct7_5);
                alu_op  = alu_dec[2:0];
                state_d = alu_dec[3] ? StWbAlu : StIllegal;
            end
            StExecI: begin
                // Immediate forms have no SUB; funct7_5 is part of the immediate.
                alu_src_b = 1'b1;
                alu_dec   = decode_alu(funct3, 1'b0);
                alu_op    = alu_dec[2:0];
                state_d   = alu_dec[3] ? StWbAlu : StIllegal;
            end
            StMemAddr: begin
                alu_src_b = 1'b1;
                state_d   = (opcode == OpLoad) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d = StWbMem;
                end
            end
            StMemWr: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
                if (dmem_ready) begin
                    state_d = StFetch;
                end
            end
            StWbAlu: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                result_src = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                // The ALU compares rs1 - rs2. PC was already advanced in FETCH,
                // so only a taken branch reloads it.
                alu_op = AluSub;
                pc_src = 1'b1;
                case (funct3)
                    3'b000: begin
                        pc_write = alu_zero;
                        state_d  = StFetch;
                    end
                    3'b001: begin
                        pc_write = !alu_zero;
                        state_d  = StFetch;
                    end
                    default: state_d = StIllegal;
                endcase
            end
            StIllegal: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Hold every request and enable low while reset is asserted. This lets
        // memory see an in-flight access dropped without a stray strobe.
        if (!reset) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_b  = 1'b0;
            result_src = 1'b0;
            alu_op     = AluAdd;
            illegal    = 1'b0;
        end
    end

    assign state_out = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [XLEN-1:0] cycle_q;
    logic [XLEN-1:0] instret_q;
    logic            retire;

    // Final cycle of a completed instruction. A branch with an unsupported
    // funct3 goes to ILLEGAL and does not retire.
    always_comb begin
        retire = (state_q == StWbAlu) || (state_q == StWbMem) ||
                 ((state_q == StMemWr) && dmem_ready) ||
                 ((state_q == StBranch) && (funct3[2:1] == 2'b00));
    end

    // Free-running performance counters; both wrap modulo 2^XLEN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + XLEN'(1);
            if (retire) begin
                instret_q <= instret_q + XLEN'(1);
            end
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller.
// The driver walks each instruction through its expected cycle list and queues
// one expected output record per cycle. A monitor on the falling edge pops each
// record and compares it with the DUT outputs. Under MULTICYCLE_CTRL_PERF_EN the
// counters are modelled; otherwise they are expected to read zero.
module tb_multicycle_controller;

    localparam int unsigned XLEN = 32;

`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // Control bundle bit positions:
    // {imem_req, dmem_req, dmem_we, pc_write, pc_src, ir_write, reg_write,
    //  alu_src_b, result_src}.
    localparam logic [8:0] C_IREQ = 9'h100;
    localparam logic [8:0] C_DREQ = 9'h080;
    localparam logic [8:0] C_DWE  = 9'h040;
    localparam logic [8:0] C_PCW  = 9'h020;
    localparam logic [8:0] C_PCS  = 9'h010;
    localparam logic [8:0] C_IRW  = 9'h008;
    localparam logic [8:0] C_RW   = 9'h004;
    localparam logic [8:0] C_SRCB = 9'h002;
    localparam logic [8:0] C_RES  = 9'h001;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [6:0]      opcode = '0;
    logic [2:0]      funct3 = '0;
    logic            funct7_5 = 1'b0;
    logic            alu_zero = 1'b0;
    logic            imem_ready = 1'b0;
    logic            dmem_ready = 1'b0;
    logic            imem_req, dmem_req, dmem_we, pc_write, pc_src, ir_write;
    logic            reg_write, alu_src_b, result_src, illegal;
    logic [2:0]      alu_op;
    logic [3:0]      state_out;
    logic [XLEN-1:0] cycle_count, instret_count;

    multicycle_controller #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .alu_zero      (alu_zero),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .alu_op        (alu_op),
        .illegal       (illegal),
        .state_out     (state_out),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      st;
        logic [12:0]     ctl;
        logic [XLEN-1:0] cyc;
        logic [XLEN-1:0] ret;
    } exp_t;

    exp_t            expq[$];
    int              tests = 0;
    int              fails = 0;
    logic [XLEN-1:0] m_cyc = '0;
    logic [XLEN-1:0] m_ret = '0;
    logic [3:0]      m_st = '0;
    logic [2:0]      alu_tbl [8] = '{3'd0, 3'd5, 3'd7, 3'd0, 3'd4, 3'd6, 3'd3, 3'd2};
    exp_t            mon_e;
    logic [12:0]     mon_got;
    logic [31:0]     instr;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: one expected record per cycle, compared away from the rising edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e   = expq.pop_front();
            mon_got = {imem_req, dmem_req, dmem_we, pc_write, pc_src, ir_write, reg_write,
                       alu_src_b, result_src, alu_op, illegal};
            tests++;
            if (state_out !== mon_e.st) begin
                fails++;
                $display("FAIL state_out: got %0d expected %0d at %0t",
                         state_out, mon_e.st, $time);
            end
            tests++;
            if (mon_got !== mon_e.ctl) begin
                fails++;
                $display("FAIL controls in state %0d: got %b expected %b at %0t",
                         mon_e.st, mon_got, mon_e.ctl, $time);
            end
            tests++;
            if ({cycle_count, instret_count} !==
                {(PerfOn ? mon_e.cyc : '0), (PerfOn ? mon_e.ret : '0)}) begin
                fails++;
                $display("FAIL counters: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d at %0t",
                         cycle_count, instret_count, (PerfOn ? mon_e.cyc : '0),
                         (PerfOn ? mon_e.ret : '0), $time);
            end
        end
    end

    // One clock cycle: drive readies, queue what the DUT must show, advance.
    task automatic step(input logic [3:0] st, input logic [8:0] c, input logic [2:0] op,
                        input logic ill, input logic imr, input logic dmr,
                        input logic retire);
        exp_t e;
        imem_ready = imr;
        dmem_ready = dmr;
        e.st  = st;
        e.ctl = {c, op, ill};
        e.cyc = m_cyc;
        e.ret = m_ret;
        expq.push_back(e);
        @(posedge clk);
        #1;
        m_cyc = m_cyc + 1;
        if (retire) m_ret = m_ret + 1;
    endtask

    // Hold reset low for n cycles; cur is the state the DUT sits in beforehand.
    task automatic do_reset(input int n, input logic [3:0] cur);
        exp_t e;
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.st  = (i == 0) ? cur : 4'd0;
            e.ctl = '0;
            e.cyc = (i == 0) ? m_cyc : '0;
            e.ret = (i == 0) ? m_ret : '0;
            expq.push_back(e);
            imem_ready = rb();
            dmem_ready = rb();
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        m_cyc = '0;
        m_ret = '0;
        m_st  = 4'd0;
    endtask

    // Reference sequence for one instruction: iw/dw wait cycles on fetch/data.
    // abort stops a store mid-stall; hold is the number of ILLEGAL cycles to watch.
    task automatic run_instr(input logic [6:0] op7, input logic [2:0] f3, input logic f7,
                             input logic zero, input int iw, input int dw,
                             input bit abort, input int hold);
        logic [2:0] aop;
        logic       pcw;
        bit         bad;
        opcode   = op7;
        funct3   = f3;
        funct7_5 = f7;
        alu_zero = zero;
        m_st     = 4'd0;
        bad      = 1'b0;
        for (int i = 0; i < iw; i++) step(4'd0, C_IREQ, 3'd0, 1'b0, 1'b0, rb(), 1'b0);
        step(4'd0, C_IREQ | C_IRW | C_PCW, 3'd0, 1'b0, 1'b1, rb(), 1'b0);
        step(4'd1, 9'h0, 3'd0, 1'b0, rb(), rb(), 1'b0);
        case (op7)
            OP_R, OP_I: begin
                aop = alu_tbl[f3];
                if (op7 == OP_R && f3 == 3'd0 && f7) aop = 3'd1;
                bad = (f3 == 3'd3);
                step((op7 == OP_R) ? 4'd2 : 4'd3, (op7 == OP_R) ? 9'h0 : C_SRCB, aop, 1'b0,
                     rb(), rb(), 1'b0);
                if (!bad) step(4'd7, C_RW, 3'd0, 1'b0, rb(), rb(), 1'b1);
            end
            OP_LD: begin
                step(4'd4, C_SRCB, 3'd0, 1'b0, rb(), rb(), 1'b0);
                for (int i = 0; i < dw; i++) step(4'd5, C_DREQ, 3'd0, 1'b0, rb(), 1'b0, 1'b0);
                step(4'd5, C_DREQ, 3'd0, 1'b0, rb(), 1'b1, 1'b0);
                step(4'd8, C_RW | C_RES, 3'd0, 1'b0, rb(), rb(), 1'b1);
            end
            OP_ST: begin
                step(4'd4, C_SRCB, 3'd0, 1'b0, rb(), rb(), 1'b0);
                for (int i = 0; i < dw; i++) begin
                    step(4'd6, C_DREQ | C_DWE, 3'd0, 1'b0, rb(), 1'b0, 1'b0);
                end
                if (abort) m_st = 4'd6;
                else step(4'd6, C_DREQ | C_DWE, 3'd0, 1'b0, rb(), 1'b1, 1'b1);
            end
            OP_BR: begin
                bad = (f3 > 3'd1);
                pcw = (f3 == 3'd0) ? zero : ((f3 == 3'd1) ? !zero : 1'b0);
                step(4'd9, C_PCS | (pcw ? C_PCW : 9'h0), 3'd1, 1'b0, rb(), rb(), !bad);
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            for (int i = 0; i < hold; i++) step(4'd15, 9'h0, 3'd0, 1'b1, rb(), rb(), 1'b0);
            m_st = 4'd15;
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset(2, 4'd0);

        // add x7,x6,x5
        instr = 32'h005303b3;
        run_instr(instr[6:0], instr[14:12], instr[30], 1'b0, 0, 0, 1'b0, 0);
        // sub, then slli
        run_instr(OP_R, 3'd0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        run_instr(OP_I, 3'd1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        // load with three data wait cycles, fetch with waits
        run_instr(OP_LD, 3'd2, 1'b0, 1'b0, 0, 3, 1'b0, 0);
        run_instr(OP_LD, 3'd2, 1'b0, 1'b0, 2, 0, 1'b0, 0);
        // beq / bne with alu_zero=1, then not-zero versions
        run_instr(OP_BR, 3'd0, 1'b0, 1'b1, 0, 0, 1'b0, 0);
        run_instr(OP_BR, 3'd1, 1'b0, 1'b1, 0, 0, 1'b0, 0);
        run_instr(OP_BR, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        run_instr(OP_BR, 3'd1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        // store, then reset during a store stall followed by a clean fetch
        run_instr(OP_ST, 3'd2, 1'b0, 1'b0, 1, 1, 1'b0, 0);
        run_instr(OP_ST, 3'd2, 1'b0, 1'b0, 0, 2, 1'b1, 0);
        do_reset(1, m_st);
        run_instr(OP_R, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        // unknown opcode: ILLEGAL held 20 cycles
        run_instr(7'h7f, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 20);
        do_reset(2, m_st);
        // unsupported R-type funct3
        run_instr(OP_R, 3'd3, 1'b0, 1'b0, 0, 0, 1'b0, 3);
        do_reset(1, m_st);

        for (int n = 0; n < 150; n++) begin
            int         k;
            int         iw;
            int         dw;
            logic [2:0] f;
            k  = $urandom_range(0, 4);
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            f  = 3'($urandom_range(0, 6));
            if (f >= 3'd3) f = f + 3'd1;
            case (k)
                0:       run_instr(OP_R, f, rb(), rb(), iw, dw, 1'b0, 0);
                1:       run_instr(OP_I, f, rb(), rb(), iw, dw, 1'b0, 0);
                2:       run_instr(OP_LD, 3'd2, rb(), rb(), iw, dw, 1'b0, 0);
                3:       run_instr(OP_ST, 3'd2, rb(), rb(), iw, dw, 1'b0, 0);
                default: run_instr(OP_BR, 3'($urandom_range(0, 1)), 1'b0, rb(), iw, dw,
                                   1'b0, 0);
            endcase
        end

        for (int i = 0; i < 4 && expq.size() > 0; i++) @(posedge clk);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
